// File: rtl/cnu_minsum_serial_if.sv
// Message handshake bundle for the serial min-sum check node unit.
// Both directions use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface cnu_minsum_serial_if #(
   parameter int DATA_WIDTH = 6
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH:0]   out_data;
   logic                  out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/cnu_minsum_serial.sv
// Serial min-sum check node: collects one row of sign-magnitude messages, then emits DEGREE replies.
// Optional offset min-sum is enabled by defining CNU_OFFSET_MINSUM_EN.
module cnu_minsum_serial #(
   parameter int DATA_WIDTH = 6,
   parameter int DEGREE     = 6,
   parameter int IDX_WIDTH  = 3,
   parameter int OFFSET     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   cnu_minsum_serial_if.slave      bus,
   output logic                    busy,
   output logic                    dbg_state
);

   typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEGREE - 1);

   state_t                 state_q, state_d;
   logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  min1_q, min1_d;
   logic [DATA_WIDTH-1:0]  min2_q, min2_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic                   sprod_q, sprod_d;
   logic [DEGREE-1:0]      sign_q, sign_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;
   logic [DATA_WIDTH:0]    out_data_q, out_data_d;
   logic                   busy_q, busy_d;
   logic [DATA_WIDTH-1:0]  in_mag;
   logic                   in_hs, out_hs;

   // Reply for edge k: the row minimum excluding edge k, signed by the product of all other signs.
   function automatic logic [DATA_WIDTH:0] emit_msg(
      input logic [IDX_WIDTH-1:0]  k,
      input logic [DATA_WIDTH-1:0] m1,
      input logic [DATA_WIDTH-1:0] m2,
      input logic [IDX_WIDTH-1:0]  ix,
      input logic                  sp,
      input logic [DEGREE-1:0]     sg
   );
      logic [DATA_WIDTH-1:0] mag;
      logic                  sgn;
      mag = (k == ix) ? m2 : m1;
`ifdef CNU_OFFSET_MINSUM_EN
      mag = (mag > DATA_WIDTH'(OFFSET)) ? mag - DATA_WIDTH'(OFFSET) : '0;
`endif
      sgn = (mag == '0) ? 1'b0 : (sp ^ sg[k]);
      return {sgn, mag};
   endfunction

`ifndef CNU_OFFSET_MINSUM_EN
   logic unused_offset;
   assign unused_offset = ^32'(OFFSET);
`endif

   assign in_hs  = bus.in_valid & in_ready_q;
   assign out_hs = out_valid_q & bus.out_ready;
   assign in_mag = bus.in_data[DATA_WIDTH-1:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      min1_d      = min1_q;
      min2_d      = min2_q;
      idx_d       = idx_q;
      sprod_d     = sprod_q;
      sign_d      = sign_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      case (state_q)
         COLLECT: begin
            if (in_hs) begin
               sign_d[cnt_q] = bus.in_data[DATA_WIDTH];
               sprod_d       = sprod_q ^ bus.in_data[DATA_WIDTH];
               busy_d        = 1'b1;
               // Strict compares: on a tie the earlier edge keeps idx and the duplicate becomes min2.
               if (in_mag < min1_q) begin
                  min2_d = min1_q;
                  min1_d = in_mag;
                  idx_d  = cnt_q;
               end else if (in_mag < min2_q) begin
                  min2_d = in_mag;
               end
               if (cnt_q == LAST_IDX) begin
                  state_d     = EMIT;
                  cnt_d       = '0;
                  in_ready_d  = 1'b0;
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b0;
                  out_data_d  = emit_msg('0, min1_d, min2_d, idx_d, sprod_d, sign_d);
               end else begin
                  cnt_d = cnt_q + IDX_WIDTH'(1);
               end
            end
         end
         EMIT: begin
            if (out_hs) begin
               if (cnt_q == LAST_IDX) begin
                  state_d     = COLLECT;
                  cnt_d       = '0;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  min1_d      = '1;
                  min2_d      = '1;
                  idx_d       = '0;
                  sprod_d     = 1'b0;
               end else begin
                  cnt_d      = cnt_q + IDX_WIDTH'(1);
                  out_data_d = emit_msg(cnt_d, min1_q, min2_q, idx_q, sprod_q, sign_q);
                  out_last_d = (cnt_d == LAST_IDX);
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         cnt_q       <= '0;
         min1_q      <= '1;
         min2_q      <= '1;
         idx_q       <= '0;
         sprod_q     <= 1'b0;
         sign_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         min1_q      <= min1_d;
         min2_q      <= min2_d;
         idx_q       <= idx_d;
         sprod_q     <= sprod_d;
         sign_q      <= sign_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;
   assign dbg_state     = logic'(state_q);

endmodule

// File: doc/cnu_minsum_serial.md
Name: cnu_minsum_serial

Overview:
- Serial min-sum check node unit for the LDPC decoder.
- Sits directly downstream of the two's-complement to sign-magnitude converter. It consumes one sign-magnitude variable-to-check message per cycle for one parity row of DEGREE edges.
- It tracks min1, min2, the min1 index and the sign product, then emits DEGREE check-to-variable messages in sign-magnitude format.
- Valid/ready on both sides.

Parameters:
- DATA_WIDTH, 6, magnitude width; messages are DATA_WIDTH+1 bits (bit DATA_WIDTH = sign, bits DATA_WIDTH-1:0 = magnitude).
- DEGREE, 6, check node degree (edges per row), must be >= 2.
- IDX_WIDTH, 3, edge index width, must be >= clog2(DEGREE).
- OFFSET, 1, offset subtracted from outgoing magnitudes (used only with the optional feature).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream message valid.
- in_ready  output  1  block accepts a message this cycle.
- in_data  input  DATA_WIDTH+1  incoming sign-magnitude message.
- out_valid  output  1  outgoing message valid.
- out_ready  input  1  downstream accepts a message.
- out_data  output  DATA_WIDTH+1  outgoing sign-magnitude message.
- out_last  output  1  high with the final (index DEGREE-1) outgoing message of a row.
- busy  output  1  high whenever at least one message of the current row has been accepted and the row is not fully emitted.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - state=COLLECT, in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
  - Edge counter 0, min1 and min2 all ones, min1 index 0, sign product 0, sign store 0.
- State COLLECT:
  - in_ready=1.
  - Handshake (in_valid & in_ready) at edge k: store sign[k]=in_data[DATA_WIDTH] and XOR it into the sign product.
  - If mag < min1: min2<=min1, min1<=mag, idx<=k.
  - Else if mag < min2: min2<=mag.
  - Comparisons are strict, so on ties the earliest edge keeps idx and the equal value lands in min2.
  - Accepting edge DEGREE-1 moves the block to EMIT and clears the counter.
- State EMIT:
  - in_ready=0, out_valid=1.
  - For emit index k: magnitude = (k==idx) ? min2 : min1; sign = sign_product ^ sign[k].
  - out_data is registered.
  - Latency: first out_valid on the cycle after the last input handshake.
  - Each out handshake advances k. out_last=1 when k==DEGREE-1.
  - After the final handshake: return to COLLECT the next cycle, reinitialise min1/min2 to all ones, sign product to 0, idx to 0.
- Backpressure: while out_valid & !out_ready, out_data and out_last stay stable. in_ready stays 0 for the whole of EMIT; there is no overlap between rows.
- Zero magnitude: any outgoing message whose final magnitude is 0 is emitted with sign 0. No negative zero is emitted. Negative-zero inputs are accepted and their sign still counts in the product.
- Reset mid-operation: rst in any state abandons the partial row and restores all reset values on the next edge. No further outputs for that row.
- Idle outputs: out_data holds its last emitted value when out_valid=0.

Optional Feature:
- Macro CNU_OFFSET_MINSUM_EN.
- Defined: outgoing magnitude = max(selected_min - OFFSET, 0), saturating at 0, computed before the zero-sign rule is applied.
- Undefined: plain min-sum; the OFFSET parameter is ignored; no subtractor is present.

Test Plan:
- Basic row. DATA_WIDTH=6, DEGREE=4, inputs +5,-3,+7,-9 back-to-back.
  - Required: min1=3, idx=1, min2=5, sign product 0.
  - Outputs 0000011, 1000101, 0000011, 1000011 with out_last on the 4th.
  - First out_valid exactly 1 cycle after the 4th input handshake.
- Tie. Inputs +4,+4,+6,+8 -> idx=0, min2=4; all four outputs 0000100.
- Backpressure. Basic row with out_ready low for 3 cycles at emit index 1.
  - out_data holds 1000101 for those cycles; in_ready stays 0 until 1 cycle after the out_last handshake.
- Reset mid-row. Accept +2,-1, assert rst one cycle, then send the basic row -> outputs identical to the basic row case.
- Offset feature, compiled with CNU_OFFSET_MINSUM_EN and OFFSET=1.
  - Basic row -> 0000010, 1000100, 0000010, 1000010.
  - Inputs -1,+1,+2,+3 -> all four outputs 0000000 (zero-sign rule).
- Back-to-back rows. Two basic rows with in_valid held high and out_ready=1.
  - The second row is accepted starting the cycle after the first row's out_last handshake and produces identical outputs.
